// File: rtl/iob_cache_arbiter.sv
// Round-robin arbiter that shares one IOb cache front-end port among NREQ requesters,
// with a flush sequencer: invalidate pulse, then wait for the write-through buffer to empty.
module iob_cache_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NBYTES = DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*ADDR_W-1:0]   addr_i,
  input  logic [NREQ*DATA_W-1:0]   wdata_i,
  input  logic [NREQ*NBYTES-1:0]   wstrb_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [NREQ-1:0]          ack_o,
  output logic                     cache_req_o,
  output logic [ADDR_W-1:0]        cache_addr_o,
  output logic [DATA_W-1:0]        cache_wdata_o,
  output logic [NBYTES-1:0]        cache_wstrb_o,
  input  logic [DATA_W-1:0]        cache_rdata_i,
  input  logic                     cache_ack_i,
  input  logic                     flush_i,
  output logic                     invalidate_o,
  input  logic                     wtb_empty_i,
  output logic                     flush_busy_o,
  output logic [NREQ-1:0]          grant_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StInv, StDrain} state_e;

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [IdxW-1:0]   last_q;
  logic              flush_pend_q;
  logic              cache_req_q;
  logic              invalidate_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NBYTES-1:0] wstrb_q;

  logic              hi_valid, lo_valid, pick_valid;
  logic [IdxW-1:0]   hi_idx, lo_idx, pick_idx;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic [NBYTES-1:0] pick_wstrb;
  logic              ack_valid;

  // Requesters above last win over those at or below it; lowest index wins within a group.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        if (k > int'(last_q)) begin
          hi_valid = 1'b1;
          hi_idx   = IdxW'(k);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = IdxW'(k);
        end
      end
    end
    pick_valid = hi_valid | lo_valid;
    pick_idx   = hi_valid ? hi_idx : lo_idx;
  end

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_wstrb = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (pick_idx == IdxW'(k)) begin
        pick_addr  = addr_i[k*ADDR_W +: ADDR_W];
        pick_wdata = wdata_i[k*DATA_W +: DATA_W];
        pick_wstrb = wstrb_i[k*NBYTES +: NBYTES];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_q       <= IdxW'(NREQ - 1);
      flush_pend_q <= 1'b0;
      cache_req_q  <= 1'b0;
      invalidate_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      if (flush_i) flush_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (flush_pend_q) begin
            state_q      <= StInv;
            invalidate_q <= 1'b1;
          end else if (pick_valid) begin
            state_q     <= StBusy;
            grant_q     <= NREQ'(1) << pick_idx;
            last_q      <= pick_idx;
            cache_req_q <= 1'b1;
            addr_q      <= pick_addr;
            wdata_q     <= pick_wdata;
            wstrb_q     <= pick_wstrb;
          end
        end
        StBusy: begin
          if (cache_ack_i) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            cache_req_q <= 1'b0;
          end
        end
        StInv: begin
          state_q      <= StDrain;
          invalidate_q <= 1'b0;
        end
        StDrain: begin
          if (wtb_empty_i) begin
            state_q      <= StIdle;
            // A pulse coinciding with the exit re-arms the flush.
            flush_pend_q <= flush_i;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && cache_ack_i) begin
      assert (state_q == StBusy)
        else $warning("iob_cache_arbiter: protocol error, cache ack with no transaction");
    end
  end

  assign ack_valid     = (state_q == StBusy) && cache_ack_i;
  assign ack_o         = ack_valid ? grant_q : '0;
  assign rdata_o       = ack_valid ? cache_rdata_i : '0;
  assign cache_req_o   = cache_req_q;
  assign cache_addr_o  = addr_q;
  assign cache_wdata_o = wdata_q;
  assign cache_wstrb_o = wstrb_q;
  assign invalidate_o  = invalidate_q;
  assign flush_busy_o  = flush_pend_q;
  assign grant_o       = grant_q;

endmodule
